// File: rtl/key_expansion_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : key_expansion_pkg                                               |
// | Purpose  : Shared types, Rcon table and Nk/Nr/Nw lookups for key expansion |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package key_expansion_pkg;

    localparam int c_MAX_NK = 8;

    typedef enum logic [1:0] {
        KL_128     = 2'b00,
        KL_192     = 2'b01,
        KL_256     = 2'b10,
        KL_ILLEGAL = 2'b11
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] nw_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 6'd52;
            KL_256:  return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_expansion_gen_if.sv
// +----------------------------------------------------------------------------+
// | Module   : key_expansion_gen_if                                            |
// | Purpose  : Control and round-key read bus of the key expander              |
// |            (rd_reverse present only with KEYEXP_REVERSE_RD_EN)             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface key_expansion_gen_if #(
    parameter int MAX_KEY_L = 256,
    parameter int DATA_W    = 128
) ();

    logic                 start;
    logic [1:0]           key_len;
    logic [MAX_KEY_L-1:0] cipher_key;
    logic                 ready;
    logic                 done;
    logic                 keys_valid;
    logic                 cfg_err;
    logic                 rd_en;
    logic [3:0]           rd_round;
    logic [DATA_W-1:0]    rd_key;
    logic                 rd_valid;
    logic                 rd_err;
`ifdef KEYEXP_REVERSE_RD_EN
    logic                 rd_reverse;
`endif

    modport master (
`ifdef KEYEXP_REVERSE_RD_EN
        output rd_reverse,
`endif
        output start, key_len, cipher_key, rd_en, rd_round,
        input  ready, done, keys_valid, cfg_err, rd_key, rd_valid, rd_err
    );

    modport slave (
`ifdef KEYEXP_REVERSE_RD_EN
        input  rd_reverse,
`endif
        input  start, key_len, cipher_key, rd_en, rd_round,
        output ready, done, keys_valid, cfg_err, rd_key, rd_valid, rd_err
    );

endinterface

`default_nettype wire

// File: rtl/aes_sub_word.sv
// +----------------------------------------------------------------------------+
// | Module   : aes_sub_word                                                    |
// | Purpose  : 32-bit AES SubWord, four parallel S-box lookups                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_sub_word (
    input  wire logic [31:0] i_word,
    output logic      [31:0] o_word
);

    // Entry 0 sits in the top byte; the bit position of entry x is 8*(255-x)+7.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar b = 0; b < 4; b++) begin : g_byte
        logic [10:0] w_pos;
        assign w_pos              = {~i_word[8*b +: 8], 3'b111};
        assign o_word[8*b +: 8]   = c_SBOX[w_pos -: 8];
    end

endmodule

`default_nettype wire

// File: rtl/key_expansion_gen.sv
// +----------------------------------------------------------------------------+
// | Module   : key_expansion_gen                                               |
// | Purpose  : Iterative AES-128/192/256 key expander, one word per cycle,     |
// |            with a registered round-key read port.                          |
// |            Option macro: KEYEXP_REVERSE_RD_EN (inverse-order reads)        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module key_expansion_gen
    import key_expansion_pkg::*;
#(
    parameter int MAX_KEY_L  = 256,
    parameter int DATA_W     = 128,
    parameter int MAX_ROUNDS = 14
) (
    input  wire logic          clk,
    input  wire logic          reset,
    key_expansion_gen_if.slave bus
);

    localparam int c_NUM_WORDS = 4 * (MAX_ROUNDS + 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [3:0]        r_nk;
    logic [3:0]        r_nr;
    logic [5:0]        r_nw;
    logic [5:0]        r_idx;
    logic [2:0]        r_mod;
    logic [3:0]        r_rcon_idx;
    logic              r_done;
    logic              r_keys_valid;
    logic              r_cfg_err;
    logic [31:0]       r_store [c_NUM_WORDS];
    logic [DATA_W-1:0] r_rd_key;
    logic              r_rd_valid;
    logic              r_rd_err;

    logic              w_accept;
    logic              w_cfg_err;
    logic              w_expand_we;
    logic              w_last;
    logic [3:0]        w_nk_new;
    logic [31:0]       w_key_words [c_MAX_NK];
    logic [31:0]       w_prev;
    logic [31:0]       w_back;
    logic [31:0]       w_sub_in;
    logic [31:0]       w_sub_out;
    logic [31:0]       w_temp;
    logic [31:0]       w_new;
    logic [3:0]        w_eff_round;
    logic [5:0]        w_base;

    for (genvar k = 0; k < c_MAX_NK; k++) begin : g_key_word
        assign w_key_words[k] = bus.cipher_key[MAX_KEY_L-1-32*k -: 32];
    end

    assign w_nk_new = nk_of(bus.key_len);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cfg_err   = 1'b0;
        w_expand_we = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    if (bus.key_len == KL_ILLEGAL) begin
                        w_cfg_err = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_EXPAND;
                    end
                end
            end
            ST_EXPAND: begin
                w_expand_we = 1'b1;
                if (r_idx == (r_nw - 6'd1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // One shared SubWord: RotWord feeds it on Nk boundaries, the raw word on the AES-256 midpoint.
    assign w_prev   = r_store[r_idx - 6'd1];
    assign w_back   = r_store[r_idx - {2'b00, r_nk}];
    assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_temp = w_prev;
        if (r_mod == 3'd0) begin
            w_temp = w_sub_out ^ {rcon_lut(r_rcon_idx), 24'h000000};
        end else if ((r_nk == 4'd8) && (r_mod == 3'd4)) begin
            w_temp = w_sub_out;
        end
    end

    assign w_new = w_back ^ w_temp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nk         <= 4'd4;
            r_nr         <= 4'd10;
            r_nw         <= 6'd44;
            r_idx        <= 6'd0;
            r_mod        <= 3'd0;
            r_rcon_idx   <= 4'd0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_done    <= w_last;
            r_cfg_err <= w_cfg_err;
            if (w_accept) begin
                r_nk         <= w_nk_new;
                r_nr         <= nr_of(bus.key_len);
                r_nw         <= nw_of(bus.key_len);
                r_idx        <= {2'b00, w_nk_new};
                r_mod        <= 3'd0;
                r_rcon_idx   <= 4'd0;
                r_keys_valid <= 1'b0;
            end else if (w_expand_we) begin
                r_idx <= r_idx + 6'd1;
                if ({1'b0, r_mod} == (r_nk - 4'd1)) begin
                    r_mod      <= 3'd0;
                    r_rcon_idx <= r_rcon_idx + 4'd1;
                end else begin
                    r_mod <= r_mod + 3'd1;
                end
                if (w_last) begin
                    r_keys_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < c_NUM_WORDS; j++) begin
                r_store[j] <= '0;
            end
        end else begin
            for (int j = 0; j < c_MAX_NK; j++) begin
                if (w_accept && (4'(j) < w_nk_new)) begin
                    r_store[j] <= w_key_words[j];
                end
            end
            if (w_expand_we) begin
                r_store[r_idx] <= w_new;
            end
        end
    end

    // Range check uses the requested round; reverse mapping only picks which entry is returned.
`ifdef KEYEXP_REVERSE_RD_EN
    assign w_eff_round = bus.rd_reverse ? (r_nr - bus.rd_round) : bus.rd_round;
`else
    assign w_eff_round = bus.rd_round;
`endif
    assign w_base = {w_eff_round, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_key   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                if (r_keys_valid && (bus.rd_round <= r_nr)) begin
                    r_rd_key <= {r_store[w_base], r_store[w_base + 6'd1],
                                 r_store[w_base + 6'd2], r_store[w_base + 6'd3]};
                    r_rd_err <= 1'b0;
                end else begin
                    r_rd_key <= '0;
                    r_rd_err <= 1'b1;
                end
            end else begin
                r_rd_err <= 1'b0;
            end
        end
    end

    assign bus.ready      = (r_state != ST_EXPAND);
    assign bus.done       = r_done;
    assign bus.keys_valid = r_keys_valid;
    assign bus.cfg_err    = r_cfg_err;
    assign bus.rd_key     = r_rd_key;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_err     = r_rd_err;

endmodule

`default_nettype wire

// File: tb/tb_key_expansion_gen.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_key_expansion_gen                                            |
// | Purpose  : Self-checking bench for key_expansion_gen against a FIPS-197    |
// |            model (S-box derived from GF(2^8) arithmetic)                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_key_expansion_gen;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sbox_t [256];
    logic [31:0] m_w [60];

    always #5 clk = ~clk;

    key_expansion_gen_if bus ();

    key_expansion_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] key, input int kl);
        int          nk;
        int          nw;
        logic [31:0] t;
        logic [7:0]  rc;
        nk = 4 + 2 * kl;
        nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) m_w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = m_w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int e = 0; e < i / nk - 1; e++) rc = gf_mul(rc, 8'h02);
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            m_w[i] = m_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_round(input int r);
        return {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input int r, input bit exp_err);
        logic [127:0] exp_key;
        exp_key = exp_err ? 128'h0 : model_round(r);
        bus.rd_en    = 1'b1;
        bus.rd_round = 4'(r);
        step();
        bus.rd_en = 1'b0;
        check($sformatf("rd_valid_r%0d", r), 128'(bus.rd_valid), 128'd1);
        check($sformatf("rd_err_r%0d", r), 128'(bus.rd_err), 128'(exp_err));
        check($sformatf("rd_key_r%0d", r), bus.rd_key, exp_key);
    endtask

    // Starts a run, reads during EXPAND, optionally pulses an ignored start, then reads the top round in the done cycle.
    task automatic run_expand(input int kl, input logic [255:0] key, input int ignore_at);
        int lat;
        int nk;
        int nw;
        nk = 4 + 2 * kl;
        nw = 4 * (nk + 7);
        model_expand(key, kl);
        bus.start      = 1'b1;
        bus.key_len    = 2'(kl);
        bus.cipher_key = key;
        step();
        bus.start = 1'b0;
        check("ready_drop", 128'(bus.ready), 128'd0);
        check("kv_drop", 128'(bus.keys_valid), 128'd0);
        bus.rd_en    = 1'b1;
        bus.rd_round = 4'd0;
        step();
        bus.rd_en = 1'b0;
        check("rd_busy_err", 128'({bus.rd_valid, bus.rd_err}), 128'd3);
        check("rd_busy_key", bus.rd_key, 128'h0);
        lat = 2;
        while (lat < 80) begin
            if (bus.done) break;
            if (lat == ignore_at) begin
                bus.start      = 1'b1;
                bus.key_len    = 2'b00;
                bus.cipher_key = ~key;
            end else begin
                bus.start = 1'b0;
            end
            step();
            lat++;
        end
        bus.start = 1'b0;
        check("done_latency", 128'(lat), 128'(nw - nk + 1));
        check("done_kv", 128'(bus.keys_valid), 128'd1);
        check("done_ready", 128'(bus.ready), 128'd1);
        read_check(nk + 6, 1'b0);
        check("done_pulse", 128'(bus.done), 128'd0);
    endtask

    logic [255:0] key;
    logic [127:0] held;

    initial begin
        build_sbox();
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.key_len    = 2'b00;
        bus.cipher_key = '0;
        bus.rd_en      = 1'b0;
        bus.rd_round   = 4'd0;
`ifdef KEYEXP_REVERSE_RD_EN
        bus.rd_reverse = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        check("rst_ready", 128'(bus.ready), 128'd1);
        check("rst_outs", 128'({bus.done, bus.keys_valid, bus.cfg_err, bus.rd_valid, bus.rd_err}), 128'd0);
        check("rst_rd_key", bus.rd_key, 128'h0);

        read_check(0, 1'b1);

        bus.start   = 1'b1;
        bus.key_len = 2'b11;
        step();
        bus.start = 1'b0;
        check("cfg_err_pulse", 128'({bus.cfg_err, bus.ready, bus.keys_valid}), 128'b110);
        step();
        check("cfg_err_clear", 128'(bus.cfg_err), 128'd0);

        // AES-128 reference vector; unused low key bits randomised
        key = {128'h2b7e151628aed2a6abf7158809cf4f3c, $urandom(), $urandom(), $urandom(), $urandom()};
        run_expand(0, key, 0);
        check("aes128_r10_vec", bus.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        held = bus.rd_key;
        step();
        check("rd_hold_key", bus.rd_key, held);
        check("rd_hold_valid", 128'(bus.rd_valid), 128'd0);
        read_check(0, 1'b0);
        check("aes128_r0_vec", bus.rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_check(11, 1'b1);
        read_check(15, 1'b1);
`ifdef KEYEXP_REVERSE_RD_EN
        bus.rd_reverse = 1'b1;
        read_check(10, 1'b0);
        check("rev_r10_is_key", bus.rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_check(0, 1'b0);
        check("rev_r0_is_r10", bus.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_check(11, 1'b1);
        bus.rd_reverse = 1'b0;
`endif

        // Illegal start while DONE leaves the schedule intact
        bus.start   = 1'b1;
        bus.key_len = 2'b11;
        step();
        bus.start = 1'b0;
        check("cfg_err_done", 128'({bus.cfg_err, bus.ready, bus.keys_valid}), 128'b111);
        read_check(5, 1'b0);

        key = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, $urandom(), $urandom()};
        run_expand(1, key, 7);
        check("aes192_r12_vec", bus.rd_key, 128'he98ba06f448c773c8ecc720401002202);
        read_check(13, 1'b1);

        key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        run_expand(2, key, 30);
        check("aes256_r14_vec", bus.rd_key, 128'hfe4890d1e6188d0b046df344706c631e);
        for (int r = 0; r < 15; r++) read_check(r, 1'b0);

        // Reset in cycle T+20 of an AES-256 run
        bus.start      = 1'b1;
        bus.key_len    = 2'b10;
        bus.cipher_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()};
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 20; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_state", 128'({bus.keys_valid, bus.ready, bus.done}), 128'b010);
        begin
            bit saw_done;
            saw_done = 1'b0;
            for (int c = 0; c < 40; c++) begin
                step();
                if (bus.done) saw_done = 1'b1;
            end
            check("abort_no_done", 128'(saw_done), 128'd0);
        end
        read_check(0, 1'b1);

        key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        run_expand(0, key, 0);
        check("post_abort_r10", bus.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Random keys in every mode, checked round by round against the model
        for (int kl = 0; kl < 3; kl++) begin
            for (int n = 0; n < 2; n++) begin
                for (int j = 0; j < 8; j++) key[255 - 32*j -: 32] = $urandom();
                run_expand(kl, key, 3 + n * 5);
                for (int r = 0; r <= 10 + 2 * kl; r++) read_check(r, 1'b0);
                read_check(11 + 2 * kl, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
